clock_debug_ctrl: RTL

CLOCK_DEBUG_CTRL -- requirements
Module: clock_debug_ctrl

---
 rtl/clock_debug_pkg.sv | 58 +++++
 rtl/clock_debug_ctrl_divider.sv | 64 ++++++
 rtl/clock_debug_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/clock_debug_pkg.sv
// ---------------------------------------------------------------------------
// clock_debug_pkg
//
// Purpose : Shared types and default sizes for the CPU clock debug
//           controller. It holds the controller state encoding, the encoding
//           of the external mode selector, and a helper function that maps a
//           requested mode onto the state the controller enters when a start
//           command is accepted.
//
// Contents:
//   state_e          - controller states (HALTED, RUN, STEP, BREAK)
//   mode_e           - values presented on the 2-bit mode input
//   DEF_*            - default parameter values used by the modules
//   mode_to_state()  - mode selector -> running state
// ---------------------------------------------------------------------------
package clock_debug_pkg;

  // Controller states. HALTED is the all-zero code so a cleared register
  // always lands in the safe, non-pulsing state.
  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_BREAK  = 2'd3
  } state_e;

  // Encoding of the external mode selector.
  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_STEP  = 2'd1,
    MODE_BREAK = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  // Default sizes for the controller and its divider.
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_NUM_BP = 4;
  localparam int DEF_STEP_W = 8;
  localparam int DEF_DIV_W  = 8;

  // Width of the free-running pulse counter.
  localparam int PULSE_CNT_W = 32;

  // Map a mode selector value onto the running state it requests.
  // The reserved code maps to HALTED, so a start with mode 3 does nothing.
  function automatic state_e mode_to_state(input logic [1:0] mode_sel);
    state_e st;
    st = ST_HALTED;
    case (mode_sel)
      MODE_RUN:   st = ST_RUN;
      MODE_STEP:  st = ST_STEP;
      MODE_BREAK: st = ST_BREAK;
      default:    st = ST_HALTED;
    endcase
    return st;
  endfunction

endpackage : clock_debug_pkg

// File: rtl/clock_debug_ctrl_divider.sv
// ---------------------------------------------------------------------------
// clk_en_divider
//
// Purpose : Spacing counter for the CPU clock-enable pulses. After every
//           issued pulse the counter is loaded with the divider value and
//           then counts down once per cycle; a new pulse is due when it
//           reaches zero. A divider of 0 therefore allows a pulse every
//           cycle, and a divider of N spaces pulses N+1 cycles apart.
//           Because the divider value is only sampled on a load, changing
//           it mid-run affects the spacing after the next pulse.
//
// Ports   :
//   clk       in   system clock
//   rst       in   asynchronous reset, active low
//   clear     in   force the counter to zero (controller is halting/halted)
//   load      in   a pulse is being issued this cycle; reload from div
//   count_en  in   controller is active and waiting; count down one
//   div       in   [DIV_W] pulse spacing minus one
//   due       out  counter is at zero, so a pulse may be issued this cycle
// ---------------------------------------------------------------------------
module clk_en_divider
  import clock_debug_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             count_en,
  input  logic [DIV_W-1:0] div,
  output logic             due
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // A pulse is due whenever the spacing counter has run out.
  assign due = (cnt_q == '0);

  // Next-count selection. Clearing wins over loading so a halt in the same
  // cycle as a would-be pulse leaves the counter parked at zero; this makes
  // the very first pulse after a start available immediately.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = div;
    end else if (count_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  // Counter register with asynchronous reset to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : clk_en_divider

// File: rtl/clock_debug_ctrl.sv
// ---------------------------------------------------------------------------
// clock_debug_ctrl
//
// Purpose : Debug clock controller for a CPU. It gates the CPU by issuing
//           single-cycle clock-enable pulses and supports three ways of
//           running:
//             RUN   - pulse continuously until halted by command
//             STEP  - issue a captured number of pulses, then halt
//             BREAK - pulse continuously, halting in place of a pulse when
//                     the CPU address matches an enabled breakpoint
//           A start command is a rising edge on cmd_start and is only
//           accepted while halted. cmd_halt forces the controller back to
//           HALTED and overrides everything else. All outputs are
//           registered.
//
// Ports   :
//   clk         in   system clock
//   rst         in   asynchronous reset, active low
//   mode        in   [2]  0 RUN, 1 STEP, 2 BREAK, 3 reserved
//   cmd_start   in   start level; a rising edge requests a start
//   cmd_halt    in   halt level; acts on every cycle it is high
//   step_count  in   [STEP_W] pulses per STEP command (0 means 1)
//   div         in   [DIV_W] pulse spacing minus one
//   bp_addr     in   [NUM_BP*ADDR_W] breakpoint addresses, channel i at
//                    [i*ADDR_W +: ADDR_W]
//   bp_valid    in   [NUM_BP] per-channel breakpoint enable
//   cpu_addr    in   [ADDR_W] current CPU address
//   cpu_clk_en  out  single-cycle CPU clock-enable pulse
//   busy        out  controller is not halted
//   halted      out  controller is halted
//   bp_hit      out  [NUM_BP] channels that matched at the last break stop
//   pulse_cnt   out  [32] total pulses issued, wrapping
// ---------------------------------------------------------------------------
module clock_debug_ctrl
  import clock_debug_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_BP = DEF_NUM_BP,
  parameter int STEP_W = DEF_STEP_W,
  parameter int DIV_W  = DEF_DIV_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mode,
  input  logic                     cmd_start,
  input  logic                     cmd_halt,
  input  logic [STEP_W-1:0]        step_count,
  input  logic [DIV_W-1:0]         div,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]        bp_valid,
  input  logic [ADDR_W-1:0]        cpu_addr,
  output logic                     cpu_clk_en,
  output logic                     busy,
  output logic                     halted,
  output logic [NUM_BP-1:0]        bp_hit,
  output logic [PULSE_CNT_W-1:0]   pulse_cnt
);

  // Controller state and registered outputs.
  state_e                   state_q, state_d;
  logic                     start_prev_q;
  logic [STEP_W-1:0]        step_rem_q, step_rem_d;
  logic [NUM_BP-1:0]        bp_hit_q, bp_hit_d;
  logic [PULSE_CNT_W-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic                     cpu_clk_en_q;
  logic                     busy_q;
  logic                     halted_q;

  // Internal decode.
  logic                     start_edge;
  logic                     fire;
  logic                     div_due;
  logic                     div_clear;
  logic                     div_count;
  logic [NUM_BP-1:0]        bp_match;

  // A start request is a rising edge on cmd_start. The history flop resets
  // high so a level held through reset release is not mistaken for an edge.
  assign start_edge = cmd_start & ~start_prev_q;

  // Per-channel breakpoint compare against the live CPU address. Several
  // channels may match at once; all of them are reported.
  always_comb begin
    bp_match = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      bp_match[i] = bp_valid[i] && (bp_addr[i*ADDR_W +: ADDR_W] == cpu_addr);
    end
  end

  // Next-state and pulse decision.
  //
  // The pulse that accompanies an accepted start is issued from HALTED on
  // the same edge that enters the running state, so it appears in the very
  // next cycle. Because that first pulse never passes through the BREAK
  // branch, a resume from a breakpoint address always advances the CPU.
  //
  // step_rem holds the number of pulses still owed after the one being
  // issued. Once it reaches zero the next edge halts, independent of the
  // divider, so HALTED follows the last step pulse directly.
  always_comb begin
    state_d    = state_q;
    step_rem_d = step_rem_q;
    bp_hit_d   = bp_hit_q;
    fire       = 1'b0;

    if (cmd_halt) begin
      state_d = ST_HALTED;
    end else begin
      case (state_q)
        ST_HALTED: begin
          if (start_edge) begin
            bp_hit_d = '0;
            if (mode != MODE_RSVD) begin
              state_d    = mode_to_state(mode);
              fire       = 1'b1;
              step_rem_d = (step_count == '0) ? '0 : (step_count - STEP_W'(1));
            end
          end
        end

        ST_RUN: begin
          fire = div_due;
        end

        ST_STEP: begin
          if (step_rem_q == '0) begin
            state_d = ST_HALTED;
          end else if (div_due) begin
            fire       = 1'b1;
            step_rem_d = step_rem_q - STEP_W'(1);
          end
        end

        ST_BREAK: begin
          if (div_due) begin
            if (|bp_match) begin
              state_d  = ST_HALTED;
              bp_hit_d = bp_match;
            end else begin
              fire = 1'b1;
            end
          end
        end

        default: begin
          state_d = ST_HALTED;
        end
      endcase
    end

    pulse_cnt_d = pulse_cnt_q + PULSE_CNT_W'(fire);
  end

  // The divider is parked at zero whenever the controller is (or is about
  // to be) halted, and only counts down while a running state waits for
  // its next pulse.
  assign div_clear = (state_d == ST_HALTED);
  assign div_count = (state_q != ST_HALTED) && !div_due;

  clk_en_divider #(
    .DIV_W (DIV_W)
  ) u_divider (
    .clk      (clk),
    .rst      (rst),
    .clear    (div_clear),
    .load     (fire),
    .count_en (div_count),
    .div      (div),
    .due      (div_due)
  );

  // Controller registers. Status outputs are registered from the next
  // state so they always agree with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_HALTED;
      start_prev_q <= 1'b1;
      step_rem_q   <= '0;
      bp_hit_q     <= '0;
      pulse_cnt_q  <= '0;
      cpu_clk_en_q <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      start_prev_q <= cmd_start;
      step_rem_q   <= step_rem_d;
      bp_hit_q     <= bp_hit_d;
      pulse_cnt_q  <= pulse_cnt_d;
      cpu_clk_en_q <= fire;
      busy_q       <= (state_d != ST_HALTED);
      halted_q     <= (state_d == ST_HALTED);
    end
  end

  assign cpu_clk_en = cpu_clk_en_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign bp_hit     = bp_hit_q;
  assign pulse_cnt  = pulse_cnt_q;

endmodule : clock_debug_ctrl
